// File: rtl/tdm_demux13.sv
// tdm_demux13: receive-side 13-channel TDM demultiplexer with frame-lock tracking.
// Optional feature macro TDM_PARITY_EN appends an even-parity slot to every frame.
module tdm_demux13 #(
  parameter int unsigned NUM_CH = 13,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_din,
  input  logic              i_din_valid,
  input  logic              i_frame_sync,
  output logic [NUM_CH-1:0] o_dout,
  output logic              o_frame_valid,
  output logic [CNT_W-1:0]  o_slot,
  output logic              o_locked,
  output logic              o_sync_err,
  output logic              o_parity_err
);

`ifdef TDM_PARITY_EN
  localparam int unsigned LAST = NUM_CH;
`else
  localparam int unsigned LAST = NUM_CH - 1;
`endif
  localparam logic [CNT_W-1:0] LastSlot = CNT_W'(LAST);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_slot, w_slot_d;
  logic [NUM_CH-1:0]  r_shadow, w_shadow_d;
  logic [NUM_CH-1:0]  r_dout, w_dout_d;
  logic               r_frame_valid, w_frame_valid_d;
  logic               r_sync_err, w_sync_err_d;
  logic               r_parity_err, w_parity_err_d;
  logic [NUM_CH-1:0]  w_shadow_wr;

`ifdef TDM_PARITY_EN
  logic               w_parity_ok;
  assign w_parity_ok = ~((^r_shadow) ^ i_din);
`endif

  // Shadow with the current sample steered into its slot position.
  always_comb begin
    w_shadow_wr = r_shadow;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (r_slot == CNT_W'(k)) begin
        w_shadow_wr[k] = i_din;
      end
    end
  end

  always_comb begin
    w_state_d        = r_state;
    w_slot_d         = r_slot;
    w_shadow_d       = r_shadow;
    w_dout_d         = r_dout;
    w_frame_valid_d  = 1'b0;
    w_sync_err_d     = 1'b0;
    w_parity_err_d   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_din_valid && i_frame_sync) begin
          w_shadow_d    = '0;
          w_shadow_d[0] = i_din;
          w_slot_d      = CNT_W'(1);
          w_state_d     = StRun;
        end
      end
      StRun: begin
        if (i_din_valid) begin
          if (i_frame_sync) begin
            // Sync anywhere but slot 0 drops the partial frame and restarts it.
            if (r_slot != '0) begin
              w_sync_err_d = 1'b1;
            end
            w_shadow_d    = '0;
            w_shadow_d[0] = i_din;
            w_slot_d      = CNT_W'(1);
          end else if (r_slot == '0) begin
            // Slot 0 without sync: lock lost, sample discarded.
            w_sync_err_d = 1'b1;
            w_shadow_d   = '0;
            w_state_d    = StIdle;
          end else if (r_slot == LastSlot) begin
            w_slot_d   = '0;
            w_shadow_d = '0;
`ifdef TDM_PARITY_EN
            if (w_parity_ok) begin
              w_dout_d        = r_shadow;
              w_frame_valid_d = 1'b1;
            end else begin
              w_parity_err_d  = 1'b1;
            end
`else
            w_dout_d        = w_shadow_wr;
            w_frame_valid_d = 1'b1;
`endif
          end else begin
            w_shadow_d = w_shadow_wr;
            w_slot_d   = r_slot + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_slot        <= '0;
      r_shadow      <= '0;
      r_dout        <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_parity_err  <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_slot        <= w_slot_d;
      r_shadow      <= w_shadow_d;
      r_dout        <= w_dout_d;
      r_frame_valid <= w_frame_valid_d;
      r_sync_err    <= w_sync_err_d;
      r_parity_err  <= w_parity_err_d;
    end
  end

  assign o_dout        = r_dout;
  assign o_frame_valid = r_frame_valid;
  assign o_slot        = r_slot;
  assign o_locked      = (r_state == StRun);
  assign o_sync_err    = r_sync_err;
  assign o_parity_err  = r_parity_err;

endmodule

// File: tb/tb_tdm_demux13.sv
// tb_tdm_demux13: table vectors, directed corner sequences and random stimulus
// against a frame-level queue model of the receiver.
module tb_tdm_demux13;

  localparam int NUM_CH = 13;
  localparam int CNT_W  = 4;
`ifdef TDM_PARITY_EN
  localparam int FLEN = NUM_CH + 1;
`else
  localparam int FLEN = NUM_CH;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              din = 1'b0;
  logic              din_valid = 1'b0;
  logic              frame_sync = 1'b0;
  logic [NUM_CH-1:0] dout;
  logic              frame_valid;
  logic [CNT_W-1:0]  slot;
  logic              locked;
  logic              sync_err;
  logic              parity_err;

  int n_checks = 0;
  int n_err    = 0;
  int n_fv_seen   = 0;
  int n_serr_seen = 0;

  tdm_demux13 #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_din        (din),
    .i_din_valid  (din_valid),
    .i_frame_sync (frame_sync),
    .o_dout       (dout),
    .o_frame_valid(frame_valid),
    .o_slot       (slot),
    .o_locked     (locked),
    .o_sync_err   (sync_err),
    .o_parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Frame-level model: bits of the frame in progress are kept in a queue.
  bit                m_locked = 1'b0;
  bit                m_q[$];
  logic [NUM_CH-1:0] m_dout = '0;
  bit                m_fv = 1'b0;
  bit                m_se = 1'b0;
  bit                m_pe = 1'b0;

  function automatic void model_step(input bit r, input bit v, input bit s, input bit d);
    logic [NUM_CH-1:0] val;
    int ones;
    m_fv = 1'b0;
    m_se = 1'b0;
    m_pe = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_q.delete();
      m_dout = '0;
      return;
    end
    if (!v) return;
    if (!m_locked) begin
      if (s) begin
        m_q.delete();
        m_q.push_back(d);
        m_locked = 1'b1;
      end
      return;
    end
    if (s) begin
      if (m_q.size() != 0) m_se = 1'b1;
      m_q.delete();
      m_q.push_back(d);
      return;
    end
    if (m_q.size() == 0) begin
      m_locked = 1'b0;
      m_se = 1'b1;
      return;
    end
    m_q.push_back(d);
    if (m_q.size() == FLEN) begin
      val  = '0;
      ones = 0;
      for (int k = 0; k < NUM_CH; k++) val[k] = m_q[k];
      for (int k = 0; k < FLEN; k++) ones += int'(m_q[k]);
      if (ones % 2 == 0 || FLEN == NUM_CH) begin
        m_dout = val;
        m_fv   = 1'b1;
      end else begin
        m_pe = 1'b1;
      end
      m_q.delete();
    end
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic cycle(input bit r, input bit v, input bit s, input bit d);
    rst        = r;
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    model_step(r, v, s, d);
    #1;
    chk("model dout", 32'(dout), 32'(m_dout));
    chk("model frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("model sync_err", 32'(sync_err), 32'(m_se));
    chk("model parity_err", 32'(parity_err), 32'(m_pe));
    chk("model locked", 32'(locked), 32'(m_locked));
    chk("model slot", 32'(slot), m_locked ? 32'(m_q.size()) : 32'd0);
    n_fv_seen   += int'(frame_valid);
    n_serr_seen += int'(sync_err);
  endtask

  task automatic send_frame(input logic [NUM_CH-1:0] val, input int gap_at, input int gap_len,
                            input bit bad_par);
    bit b;
    for (int k = 0; k < FLEN; k++) begin
      if (k == gap_at) repeat (gap_len) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      b = (k < NUM_CH) ? val[k] : ((^val) ^ bad_par);
      cycle(1'b0, 1'b1, (k == 0), b);
    end
  endtask

  typedef struct {
    bit                r, v, s, d;
    logic [NUM_CH-1:0] dout;
    bit                fv, se, lk;
    int                slot;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input bit v, input bit s, input bit d,
                              input logic [NUM_CH-1:0] edout, input bit fv, input bit se,
                              input bit lk, input int sl);
    vec_t e;
    e.r = r; e.v = v; e.s = s; e.d = d;
    e.dout = edout; e.fv = fv; e.se = se; e.lk = lk; e.slot = sl;
    tbl.push_back(e);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH-1:0] pat;
    int fv0, se0;
    bit rr, vv, ss;

    // Reset and idle vectors.
    add(1, 0, 0, 0, '0, 0, 0, 0, 0);
    add(1, 1, 1, 1, '0, 0, 0, 0, 0);
    add(0, 1, 0, 1, '0, 0, 0, 0, 0);
    add(0, 1, 0, 0, '0, 0, 0, 0, 0);
    add(0, 1, 0, 1, '0, 0, 0, 0, 0);
    add(0, 0, 1, 1, '0, 0, 0, 0, 0);
`ifndef TDM_PARITY_EN
    pat = 13'h1A5B;
    for (int k = 0; k < NUM_CH; k++) begin
      if (k == NUM_CH - 1) add(0, 1, 0, pat[k], pat, 1, 0, 1, 0);
      else add(0, 1, (k == 0), pat[k], '0, 0, 0, 1, k + 1);
    end
    add(0, 0, 0, 0, pat, 0, 0, 1, 0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d);
      chk($sformatf("tbl[%0d] dout", i), 32'(dout), 32'(tbl[i].dout));
      chk($sformatf("tbl[%0d] frame_valid", i), 32'(frame_valid), 32'(tbl[i].fv));
      chk($sformatf("tbl[%0d] sync_err", i), 32'(sync_err), 32'(tbl[i].se));
      chk($sformatf("tbl[%0d] locked", i), 32'(locked), 32'(tbl[i].lk));
      chk($sformatf("tbl[%0d] slot", i), 32'(slot), 32'(tbl[i].slot));
    end

    // Back-to-back frames, second with a 3-cycle gap.
    fv0 = n_fv_seen; se0 = n_serr_seen;
    send_frame(13'h0FFF, -1, 0, 1'b0);
    chk("b2b frame1 valid", 32'(frame_valid), 32'd1);
    chk("b2b frame1 dout", 32'(dout), 32'h0FFF);
    send_frame(13'h1001, 5, 3, 1'b0);
    chk("b2b frame2 valid", 32'(frame_valid), 32'd1);
    chk("b2b frame2 dout", 32'(dout), 32'h1001);
    chk("b2b pulse count", 32'(n_fv_seen - fv0), 32'd2);
    chk("b2b no sync_err", 32'(n_serr_seen - se0), 32'd0);

    // Early resync at slot 6.
    fv0 = n_fv_seen; se0 = n_serr_seen;
    pat = 13'h0AAA;
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, (k == 0), pat[k]);
    chk("resync slot before", 32'(slot), 32'd6);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("resync sync_err", 32'(sync_err), 32'd1);
    chk("resync dout held", 32'(dout), 32'h1001);
    chk("resync slot after", 32'(slot), 32'd1);
    pat = 13'h1234;
    for (int k = 1; k < FLEN; k++)
      cycle(1'b0, 1'b1, 1'b0, (k < NUM_CH) ? pat[k] : ^pat);
    chk("resync publish dout", 32'(dout), 32'h1234);
    chk("resync fv count", 32'(n_fv_seen - fv0), 32'd1);
    chk("resync serr count", 32'(n_serr_seen - se0), 32'd1);

    // Lock loss: slot 0 without frame_sync.
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("lockloss sync_err", 32'(sync_err), 32'd1);
    chk("lockloss locked", 32'(locked), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("lockloss stays idle", 32'(locked), 32'd0);

    // Reset at slot 8.
    fv0 = n_fv_seen;
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, (k == 0), 1'b1);
    chk("midrst slot", 32'(slot), 32'd8);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("midrst dout", 32'(dout), 32'd0);
    chk("midrst locked", 32'(locked), 32'd0);
    chk("midrst slot0", 32'(slot), 32'd0);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("midrst no publish", 32'(n_fv_seen - fv0), 32'd0);

`ifdef TDM_PARITY_EN
    send_frame(13'h0003, -1, 0, 1'b0);
    chk("parity ok valid", 32'(frame_valid), 32'd1);
    chk("parity ok dout", 32'(dout), 32'h0003);
    send_frame(13'h0003, -1, 0, 1'b1);
    chk("parity bad err", 32'(parity_err), 32'd1);
    chk("parity bad no valid", 32'(frame_valid), 32'd0);
    send_frame(13'h0005, -1, 0, 1'b1);
    chk("parity bad dout held", 32'(dout), 32'h0003);
`else
    chk("parity_err tied low", 32'(parity_err), 32'd0);
`endif

    // Random traffic, biased toward well-formed frames.
    for (int i = 0; i < 4000; i++) begin
      rr = ($urandom_range(999) == 0);
      vv = ($urandom_range(9) < 7);
      if (!m_locked || m_q.size() == 0) ss = ($urandom_range(9) < 8);
      else ss = ($urandom_range(99) < 3);
      cycle(rr, vv, ss, 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux13.md
Name: tdm_demux13

Overview:
- Receive-side counterpart of the 13-channel TDM selector.
- Accepts a 1-bit serial stream, one channel bit per valid slot, with slot 0 flagged by frame_sync.
- Steers each bit into its channel position, assembles a full frame in a shadow register, then publishes all channels in parallel with a one-cycle frame strobe.
- Sits between the serial link and per-channel consumers.

Parameters:
- NUM_CH, 13, number of channels (slots) per frame; legal range 2..16.
- CNT_W, 4, slot counter width; must satisfy 2**CNT_W >= NUM_CH+1.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial channel bit for current slot.
- din_valid  input  1  din (and frame_sync) sampled only when high.
- frame_sync  input  1  marks the current valid sample as slot 0; ignored when din_valid low.
- dout  output  NUM_CH  registered channel bits of last complete frame; bit k = slot k.
- frame_valid  output  1  one-cycle pulse when dout updated.
- slot  output  CNT_W  index of next slot expected (debug/monitor).
- locked  output  1  high while in RUN state.
- sync_err  output  1  one-cycle pulse on unexpected frame_sync mid-frame.
- parity_err  output  1  one-cycle pulse on parity mismatch (feature only; else constant 0).

Behaviour:
- Reset (rst=1 at edge): state=IDLE, slot=0, shadow=0, dout=0, frame_valid=0, sync_err=0, parity_err=0, locked=0. rst overrides all inputs on the same edge.
- FSM states: IDLE, RUN.
- IDLE:
  - din_valid=1 & frame_sync=1 → shadow[0]=din, slot=1, go RUN.
  - Any other input combination → discarded, stay IDLE.
- RUN, din_valid=0: no change; gaps of any length allowed.
- RUN, din_valid=1, frame_sync=0:
  - shadow[slot]=din; slot increments.
  - When slot==LAST (NUM_CH-1 without feature): on the same edge, dout={din, shadow[LAST-1:0]}, frame_valid=1 next cycle, slot wraps to 0, shadow cleared.
- RUN, din_valid=1, frame_sync=1:
  - slot==0: normal slot-0 capture, no error.
  - slot!=0: sync_err pulses 1 cycle; partial frame discarded (dout unchanged, no frame_valid); shadow cleared and sample written to shadow[0]; slot=1. Stays RUN.
- Slot-0 check: after wrap, if the next valid sample at slot 0 arrives with frame_sync=0 → loss of lock. Sample discarded, go IDLE, slot=0, sync_err pulses.
- Latency: frame_valid and new dout visible in the cycle after the edge that captures the last slot. Minimum frame period NUM_CH cycles; back-to-back frames supported.
- Pulse outputs (frame_valid, sync_err, parity_err): registered, high exactly one cycle per event, default 0.
- dout holds its value until the next complete, accepted frame.
- slot never exceeds LAST; wrap is explicit, not modulo 2**CNT_W.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined:
  - Frame is NUM_CH+1 slots; LAST=NUM_CH; slot NUM_CH carries even parity over the channel bits.
  - At the last slot, compare XOR(shadow[NUM_CH-1:0]) ^ din against 0.
  - Match → normal publish.
  - Mismatch → parity_err pulse, dout unchanged, no frame_valid, slot wraps to 0, stay RUN.
- Undefined: NUM_CH-slot frames, no parity slot, parity_err tied 0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → dout=0, all pulses 0, slot=0, locked=0. Valid samples with no frame_sync → stay IDLE, locked=0.
- Single frame (no feature): frame_sync on slot 0, 13 consecutive valid bits forming 13'h1A5B (LSB first) → dout=13'h1A5B, frame_valid high exactly one cycle after the 13th sample, slot=0.
- Back-to-back frames with gaps: frame 13'h0FFF then 13'h1001, din_valid deasserted 3 cycles mid-frame-2 → two frame_valid pulses. dout=13'h0FFF, then 13'h1001; gaps cause no errors.
- Early resync: frame_sync asserted at slot 6 → sync_err pulse, no frame_valid, dout retains prior value, next 13 samples publish correctly.
- Lock loss and mid-frame reset:
  - Slot 0 arrives without frame_sync → sync_err, locked=0.
  - rst at slot 8 → all outputs return to reset values next cycle; prior partial frame never published.
- TDM_PARITY_EN: 14-slot frame with data 13'h0003 and parity 0 → published. Same data with parity 1 → parity_err pulse, no frame_valid, dout unchanged.
